// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction port and a data port share one
// memory port with at most one transaction in flight, and imem is protected from starvation.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_imem_req_valid,
    input  logic [31:0] io_imem_req_bits_addr,
    output logic        io_imem_req_ready,
    output logic        io_imem_resp_valid,
    output logic [31:0] io_imem_resp_bits_data,

    input  logic        io_dmem_req_valid,
    input  logic [31:0] io_dmem_req_bits_addr,
    input  logic [31:0] io_dmem_req_bits_data,
    input  logic        io_dmem_req_bits_fcn,
    input  logic [2:0]  io_dmem_req_bits_typ,
    output logic        io_dmem_req_ready,
    output logic        io_dmem_resp_valid,
    output logic [31:0] io_dmem_resp_bits_data,

    output logic        io_mem_req_valid,
    input  logic        io_mem_req_ready,
    output logic [31:0] io_mem_req_bits_addr,
    output logic [31:0] io_mem_req_bits_data,
    output logic        io_mem_req_bits_fcn,
    output logic [2:0]  io_mem_req_bits_typ,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_bits_data
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYP_W  = 3;
    localparam logic [TYP_W-1:0] IMEM_TYP = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic [CNT_W-1:0]    starve_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                fcn_q;
    logic [TYP_W-1:0]    typ_q;

    logic in_idle;
    logic imem_pri;
    logic imem_fire;
    logic dmem_fire;
    logic resp_hit;

    assign in_idle  = (state == IDLE);
    assign imem_pri = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Readies are only offered while no transaction is in flight.
    assign io_dmem_req_ready = in_idle & ~(imem_pri & io_imem_req_valid);
    assign io_imem_req_ready = in_idle & (~io_dmem_req_valid | imem_pri);

    assign dmem_fire = io_dmem_req_valid & io_dmem_req_ready;
    assign imem_fire = io_imem_req_valid & io_imem_req_ready;

    // A response is only meaningful while waiting for one; reset masks everything.
    assign resp_hit           = (state == RESP) & io_mem_resp_valid & ~reset;
    assign io_imem_resp_valid = resp_hit & ~owner;
    assign io_dmem_resp_valid = resp_hit & owner;

    assign io_imem_resp_bits_data = io_mem_resp_bits_data;
    assign io_dmem_resp_bits_data = io_mem_resp_bits_data;

    assign io_mem_req_valid     = (state == REQ) & ~reset;
    assign io_mem_req_bits_addr = addr_q;
    assign io_mem_req_bits_data = data_q;
    assign io_mem_req_bits_fcn  = fcn_q;
    assign io_mem_req_bits_typ  = typ_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            fcn_q      <= 1'b0;
            typ_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_fire) begin
                        state  <= REQ;
                        owner  <= 1'b1;
                        addr_q <= io_dmem_req_bits_addr;
                        data_q <= io_dmem_req_bits_data;
                        fcn_q  <= io_dmem_req_bits_fcn;
                        typ_q  <= io_dmem_req_bits_typ;
                        // Count dmem grants that made a waiting imem lose.
                        if (io_imem_req_valid) begin
                            starve_cnt <= imem_pri ? starve_cnt : starve_cnt + CNT_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (imem_fire) begin
                        state      <= REQ;
                        owner      <= 1'b0;
                        addr_q     <= io_imem_req_bits_addr;
                        data_q     <= '0;
                        fcn_q      <= 1'b0;
                        typ_q      <= IMEM_TYP;
                        starve_cnt <= '0;
                    end
                end
                REQ: begin
                    if (io_mem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (io_mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios and random traffic checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_imem_req_valid;
    logic [31:0] io_imem_req_bits_addr;
    logic        io_imem_req_ready;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_bits_data;
    logic        io_dmem_req_valid;
    logic [31:0] io_dmem_req_bits_addr;
    logic [31:0] io_dmem_req_bits_data;
    logic        io_dmem_req_bits_fcn;
    logic [2:0]  io_dmem_req_bits_typ;
    logic        io_dmem_req_ready;
    logic        io_dmem_resp_valid;
    logic [31:0] io_dmem_resp_bits_data;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic [31:0] io_mem_req_bits_addr;
    logic [31:0] io_mem_req_bits_data;
    logic        io_mem_req_bits_fcn;
    logic [2:0]  io_mem_req_bits_typ;
    logic        io_mem_resp_valid;
    logic [31:0] io_mem_resp_bits_data;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_imem_req_valid      (io_imem_req_valid),
        .io_imem_req_bits_addr  (io_imem_req_bits_addr),
        .io_imem_req_ready      (io_imem_req_ready),
        .io_imem_resp_valid     (io_imem_resp_valid),
        .io_imem_resp_bits_data (io_imem_resp_bits_data),
        .io_dmem_req_valid      (io_dmem_req_valid),
        .io_dmem_req_bits_addr  (io_dmem_req_bits_addr),
        .io_dmem_req_bits_data  (io_dmem_req_bits_data),
        .io_dmem_req_bits_fcn   (io_dmem_req_bits_fcn),
        .io_dmem_req_bits_typ   (io_dmem_req_bits_typ),
        .io_dmem_req_ready      (io_dmem_req_ready),
        .io_dmem_resp_valid     (io_dmem_resp_valid),
        .io_dmem_resp_bits_data (io_dmem_resp_bits_data),
        .io_mem_req_valid       (io_mem_req_valid),
        .io_mem_req_ready       (io_mem_req_ready),
        .io_mem_req_bits_addr   (io_mem_req_bits_addr),
        .io_mem_req_bits_data   (io_mem_req_bits_data),
        .io_mem_req_bits_fcn    (io_mem_req_bits_fcn),
        .io_mem_req_bits_typ    (io_mem_req_bits_typ),
        .io_mem_resp_valid      (io_mem_resp_valid),
        .io_mem_resp_bits_data  (io_mem_resp_bits_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: one optional outstanding transaction record.
    bit          tx_open;
    bit          tx_sent;
    bit          tx_is_dmem;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_fcn;
    logic [2:0]  lat_typ;
    int          lost_grants;

    int grant_log[$];
    int imem_resp_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_open     = 1'b0;
        tx_sent     = 1'b0;
        tx_is_dmem  = 1'b0;
        lat_addr    = '0;
        lat_data    = '0;
        lat_fcn     = 1'b0;
        lat_typ     = '0;
        lost_grants = 0;
    endtask

    task automatic clear_inputs();
        reset                 = 1'b0;
        io_imem_req_valid     = 1'b0;
        io_imem_req_bits_addr = '0;
        io_dmem_req_valid     = 1'b0;
        io_dmem_req_bits_addr = '0;
        io_dmem_req_bits_data = '0;
        io_dmem_req_bits_fcn  = 1'b0;
        io_dmem_req_bits_typ  = '0;
        io_mem_req_ready      = 1'b0;
        io_mem_resp_valid     = 1'b0;
        io_mem_resp_bits_data = '0;
    endtask

    // Inputs are set at the falling edge; check, then advance the model across one rising edge.
    task automatic step();
        bit imem_first;
        bit exp_iready;
        bit exp_dready;
        bit waiting_resp;
        #1;
        imem_first = (lost_grants == LIMIT);
        exp_iready = !tx_open && (!io_dmem_req_valid || imem_first);
        exp_dready = !tx_open && !(imem_first && io_imem_req_valid);
        waiting_resp = tx_open && tx_sent && !reset;

        check_eq("imem_req_ready", 32'(io_imem_req_ready), 32'(exp_iready));
        check_eq("dmem_req_ready", 32'(io_dmem_req_ready), 32'(exp_dready));
        check_eq("mem_req_valid", 32'(io_mem_req_valid), 32'(tx_open && !tx_sent && !reset));
        check_eq("mem_req_addr", io_mem_req_bits_addr, lat_addr);
        check_eq("mem_req_data", io_mem_req_bits_data, lat_data);
        check_eq("mem_req_fcn_typ", {28'd0, io_mem_req_bits_fcn, io_mem_req_bits_typ}, {28'd0, lat_fcn, lat_typ});
        check_eq("imem_resp_valid", 32'(io_imem_resp_valid), 32'(waiting_resp && !tx_is_dmem && io_mem_resp_valid));
        check_eq("dmem_resp_valid", 32'(io_dmem_resp_valid), 32'(waiting_resp && tx_is_dmem && io_mem_resp_valid));
        check_eq("imem_resp_data", io_imem_resp_bits_data, io_mem_resp_bits_data);
        check_eq("dmem_resp_data", io_dmem_resp_bits_data, io_mem_resp_bits_data);

        if (io_dmem_req_valid && io_dmem_req_ready && !reset) grant_log.push_back(1);
        else if (io_imem_req_valid && io_imem_req_ready && !reset) grant_log.push_back(0);
        if (io_imem_resp_valid) imem_resp_cycles++;

        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (!tx_open) begin
            if (io_dmem_req_valid && exp_dready) begin
                tx_open    = 1'b1;
                tx_sent    = 1'b0;
                tx_is_dmem = 1'b1;
                lat_addr   = io_dmem_req_bits_addr;
                lat_data   = io_dmem_req_bits_data;
                lat_fcn    = io_dmem_req_bits_fcn;
                lat_typ    = io_dmem_req_bits_typ;
                if (io_imem_req_valid) lost_grants = (lost_grants < LIMIT) ? lost_grants + 1 : LIMIT;
                else lost_grants = 0;
            end else if (io_imem_req_valid && exp_iready) begin
                tx_open     = 1'b1;
                tx_sent     = 1'b0;
                tx_is_dmem  = 1'b0;
                lat_addr    = io_imem_req_bits_addr;
                lat_data    = '0;
                lat_fcn     = 1'b0;
                lat_typ     = 3'b010;
                lost_grants = 0;
            end
        end else if (!tx_sent) begin
            if (io_mem_req_ready) tx_sent = 1'b1;
        end else if (io_mem_resp_valid) begin
            tx_open = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        int n;
        int exp_log[5];
        clear_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        step();
        reset = 1'b0;

        // Single imem read with immediate memory ready and next-cycle data.
        imem_resp_cycles = 0;
        io_imem_req_valid = 1'b1;
        io_imem_req_bits_addr = 32'h0000_0100;
        step();
        io_imem_req_valid = 1'b0;
        io_imem_req_bits_addr = 32'hFFFF_FFFF;
        io_mem_req_ready = 1'b1;
        check_eq("imem_fetch_addr", io_mem_req_bits_addr, 32'h0000_0100);
        step();
        io_mem_req_ready = 1'b0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_bits_data = 32'hDEAD_BEEF;
        step();
        io_mem_resp_valid = 1'b0;
        step();
        check_eq("imem_resp_cycles", 32'(imem_resp_cycles), 32'd1);

        // Write with three stalled cycles, then ack; stray resp pulses in IDLE/REQ.
        io_mem_resp_valid = 1'b1;
        step();
        io_mem_resp_valid = 1'b0;
        io_dmem_req_valid = 1'b1;
        io_dmem_req_bits_addr = 32'h0000_0200;
        io_dmem_req_bits_data = 32'h1234_5678;
        io_dmem_req_bits_fcn = 1'b1;
        io_dmem_req_bits_typ = 3'b011;
        step();
        clear_inputs();
        io_mem_resp_valid = 1'b1;
        step();
        io_mem_resp_valid = 1'b0;
        repeat (2) step();
        io_mem_req_ready = 1'b1;
        step();
        io_mem_req_ready = 1'b0;
        io_mem_resp_valid = 1'b1;
        step();
        io_mem_resp_valid = 1'b0;

        // Reset while waiting for a response; the late pulse must be ignored.
        io_imem_req_valid = 1'b1;
        io_imem_req_bits_addr = 32'h0000_0400;
        step();
        io_imem_req_valid = 1'b0;
        io_mem_req_ready = 1'b1;
        step();
        io_mem_req_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_bits_data = 32'hBAD0_BAD0;
        step();
        io_mem_resp_valid = 1'b0;
        io_imem_req_valid = 1'b1;
        step();
        io_imem_req_valid = 1'b0;
        io_mem_req_ready = 1'b1;
        step();
        io_mem_resp_valid = 1'b1;
        io_mem_resp_bits_data = 32'h0BAD_F00D;
        step();
        clear_inputs();
        step();

        // Both requesters held valid: four dmem grants, then imem.
        reset = 1'b1;
        step();
        clear_inputs();
        grant_log.delete();
        io_imem_req_valid = 1'b1;
        io_imem_req_bits_addr = 32'h0000_1000;
        io_dmem_req_valid = 1'b1;
        io_dmem_req_bits_addr = 32'h0000_2000;
        io_mem_req_ready = 1'b1;
        io_mem_resp_valid = 1'b1;
        n = 0;
        while (grant_log.size() < 5 && n < 60) begin
            step();
            n++;
        end
        exp_log = '{1, 1, 1, 1, 0};
        check_eq("grant_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check_eq($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(exp_log[i]));
        end
        clear_inputs();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            reset                 = ($urandom_range(0, 59) == 0);
            io_imem_req_valid     = ($urandom_range(0, 2) != 0);
            io_imem_req_bits_addr = $urandom;
            io_dmem_req_valid     = ($urandom_range(0, 2) != 0);
            io_dmem_req_bits_addr = $urandom;
            io_dmem_req_bits_data = $urandom;
            io_dmem_req_bits_fcn  = 1'($urandom_range(0, 1));
            io_dmem_req_bits_typ  = 3'($urandom_range(0, 7));
            io_mem_req_ready      = 1'($urandom_range(0, 1));
            io_mem_resp_valid     = 1'($urandom_range(0, 1));
            io_mem_resp_bits_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
